seven_segment_mux_ctrl: RTL and testbench
=========================================

Name: seven_segment_mux_ctrl

Overview:
Parametrised, registered multi-source hex display controller for the board's seven-segment bank.
- Selects one of NUM_SRC hex values, either manually or by timed auto-rotation.
- Supports freeze, per-digit blink and decimal-point control.
- Drives NUM_DIGITS active-low 8-bit segment fields.
- Sits between the debug/status sources (PC, K_CD, bus probes) and the HEX pins.

Parameters:
NUM_DIGITS, 6, number of displayed hex digits; display word W = 4*NUM_DIGITS bits.
NUM_SRC, 2, number of input sources; minimum 1.
DWELL_CYCLES, 50000000, clock cycles each source is shown in auto mode; minimum 1.
BLINK_CYCLES, 25000000, clock cycles per blink half-period; minimum 1.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
src_data  input  NUM_SRC*W  flattened sources; source i at [i*W +: W].
sel  input  max(1,$clog2(NUM_SRC))  manual source index.
auto_en  input  1  1 = timed auto-rotation, sel ignored.
freeze  input  1  1 = hold the currently displayed value.
blink_mask  input  NUM_DIGITS  per-digit blink enable.
dp_mask  input  NUM_DIGITS  per-digit decimal point on.
cur_src  output  width of sel  index of the active source.
HEX  output  8*NUM_DIGITS  digit d at [8d +: 8]; bit0..6 = segments a..g, bit7 = dp; active-low.

Behaviour:
- Reset (async, rst_n=0):
  - HEX = all 1s (blank).
  - Held value = 0, cur_src = 0, dwell counter = 0, blink counter = 0, blink phase = 0.
  - Takes effect immediately, including mid-rotation or mid-blink.
- Glyph encoding: standard hex set 0-9, A, b, C, d, E, F, active-low, dp excluded.
  - Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
- Active source:
  - auto_en=0: cur_src follows sel, registered, 1-cycle latency.
  - sel >= NUM_SRC selects source 0.
  - auto_en=1: dwell counter counts 0..DWELL_CYCLES-1. On the terminal count it resets to 0 and cur_src advances by 1, wrapping NUM_SRC-1 -> 0.
  - Rising edge of auto_en: dwell counter restarts at 0; rotation starts from the current cur_src.
  - Falling edge of auto_en: cur_src takes sel on the next clock.
  - NUM_SRC=1: cur_src is constant 0.
- Value path:
  - Held value register loads src_data[cur_src] every cycle while freeze=0.
  - While freeze=1, the held value is kept; rotation and blink keep running.
  - HEX is registered from the held value.
  - Latency: a src_data change is visible on HEX 2 cycles later (held register, then HEX register).
  - A source switch costs one extra cycle for cur_src.
- Blink:
  - Blink counter counts 0..BLINK_CYCLES-1 and toggles blink phase on the terminal count, free-running.
  - When phase=1 and blink_mask[d]=1, digit d = 8'hFF, dp included.
  - A blink_mask change takes effect on the next HEX update.
- Decimal point: HEX[8d+7] = ~dp_mask[d] unless the digit is blanked by blink.
- No handshakes; all inputs are sampled each clock. Inputs are assumed synchronous to clk.

Optional Feature:
Macro SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking. Every digit above the most significant non-zero digit of the held value shows segments off (7'h7F); dp_mask is still honoured.
  - Digit 0 is always shown, so value 0 shows a single "0".
  - Blanking is evaluated on the held value, in the same registered stage as blink.
- Undefined: all digits always shown; no blanking logic is synthesised.

Test Plan:
- Parameters for the bench: NUM_DIGITS=6, NUM_SRC=4, DWELL_CYCLES=8, BLINK_CYCLES=4.
- Reset: assert rst_n=0 mid-run -> HEX=48'hFFFFFFFFFFFF and cur_src=0 immediately, before the next clk edge; release -> first value appears after 2 cycles.
- Manual select:
  - src1=24'h123456, sel=1, auto_en=0 -> after 3 cycles HEX digit0=8'h82 ('6') and digit5=8'hF9 ('1').
  - sel=5 -> source 0 shown.
- Auto-rotate: auto_en=1 -> cur_src steps 0,1,2,3,0 every 8 cycles; toggling auto_en off with sel=2 -> cur_src=2 next cycle.
- Freeze: freeze=1, then change src0 from 24'h000000 to 24'hFFFFFF -> HEX stays all-'0' (8'hC0 per digit); release -> all 8'h8E after 2 cycles.
- Blink/dp: blink_mask=6'b000001, dp_mask=6'b000010 -> digit0 alternates glyph/8'hFF every 4 cycles; digit1 bit7=0 constantly.
- SEG_LZ_BLANK_EN build: value 24'h000A05 -> digits 5..3 = 8'hFF, digit2=8'h88, digit1=8'hC0, digit0=8'h92; value 0 -> only digit0 = 8'hC0.

Source files
------------

// File: rtl/seven_segment_mux_ctrl.sv
// Purpose : picks one of NUM_SRC hex words (manual or timed rotation) and drives NUM_DIGITS active-low 7-seg+dp fields.
// Latency : src_data -> HEX 2 cycles (held reg, HEX reg); a source switch adds 1 cycle for cur_src.
// Backpressure: none; every input is sampled each clock. Optional SEG_LZ_BLANK_EN adds leading-zero blanking.
module seven_segment_mux_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int NUM_SRC      = 2,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_SRC*4*NUM_DIGITS-1:0]                   src_data,
    input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0]  sel,
    input  logic                                              auto_en,
    input  logic                                              freeze,
    input  logic [NUM_DIGITS-1:0]                             blink_mask,
    input  logic [NUM_DIGITS-1:0]                             dp_mask,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0]  cur_src,
    output logic [8*NUM_DIGITS-1:0]                           HEX
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [SEL_W-1:0]        r_cur_src;
    logic [DW_W-1:0]         r_dwell;
    logic [BL_W-1:0]         r_blink_cnt;
    logic                    r_blink_phase;
    logic [W-1:0]            r_held;
    logic [8*NUM_DIGITS-1:0] r_hex;

    logic [SEL_W-1:0]        w_sel_idx;
    logic [SEL_W-1:0]        w_next_src;
    logic [W-1:0]            w_src_sel;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [8*NUM_DIGITS-1:0] w_hex_next;

    // Active-low glyphs, bit order g..a; dp is handled separately.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Out-of-range manual selection falls back to source 0.
    always_comb begin
        w_sel_idx = sel;
        if (32'(sel) >= $unsigned(NUM_SRC)) begin
            w_sel_idx = '0;
        end
    end

    // Rotation successor with wrap at the last source.
    always_comb begin
        w_next_src = r_cur_src + SEL_W'(1);
        if (r_cur_src == SEL_W'(NUM_SRC - 1)) begin
            w_next_src = '0;
        end
    end

    // Source selection: manual tracks sel; auto advances on each dwell terminal count.
    // The dwell counter sits at 0 while auto is off, so a rising edge of auto_en starts a full dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_src <= '0;
            r_dwell   <= '0;
        end else if (!auto_en) begin
            r_cur_src <= w_sel_idx;
            r_dwell   <= '0;
        end else if (r_dwell == DW_W'(DWELL_CYCLES - 1)) begin
            r_cur_src <= w_next_src;
            r_dwell   <= '0;
        end else begin
            r_dwell   <= r_dwell + DW_W'(1);
        end
    end

    // Data mux from the flattened source bus.
    always_comb begin
        w_src_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_cur_src == SEL_W'(i)) begin
                w_src_sel = src_data[i*W +: W];
            end
        end
    end

    // Held value follows the selected source unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= '0;
        end else if (!freeze) begin
            r_held <= w_src_sel;
        end
    end

    // Free-running blink timebase; phase flips every BLINK_CYCLES clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BL_W'(1);
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic w_lz_seen;

    // Scan from the top digit down; blank until the first non-zero nibble. Digit 0 is never blanked.
    always_comb begin
        w_lz_blank = '0;
        w_lz_seen  = 1'b0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            if (r_held[4*d +: 4] != 4'h0) begin
                w_lz_seen = 1'b1;
            end
            w_lz_blank[d] = ~w_lz_seen;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    // Per-digit field: glyph (or blanked segments) plus dp; blink overrides the whole byte.
    always_comb begin
        w_hex_next = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_hex_next[8*d +: 8] = {~dp_mask[d],
                                    w_lz_blank[d] ? 7'h7F : f_glyph(r_held[4*d +: 4])};
            if (r_blink_phase && blink_mask[d]) begin
                w_hex_next[8*d +: 8] = 8'hFF;
            end
        end
    end

    // Output register; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign cur_src = r_cur_src;
    assign HEX     = r_hex;

endmodule

// File: tb/tb_seven_segment_mux_ctrl.sv
module tb_seven_segment_mux_ctrl;

    localparam logic [47:0] S654321 = 48'h829299B0A4F9;
    localparam logic [47:0] S123456 = 48'hF9A4B0999282;
    localparam logic [47:0] SABCDEF = 48'h8883C6A1868E;
    localparam logic [47:0] S789012 = 48'hF88090C0F9A4;
    localparam logic [47:0] SFFFFFF = 48'h8E8E8E8E8E8E;
    localparam logic [47:0] SBLANK  = 48'hFFFFFFFFFFFF;
`ifdef SEG_LZ_BLANK_EN
    localparam logic [47:0] EXP_ZERO    = 48'hFFFFFFFFFFC0;
    localparam logic [47:0] EXP_A05     = 48'hFFFFFF88C092;
    localparam logic [47:0] EXP_A05_DP5 = 48'h7FFFFF88C092;
`else
    localparam logic [47:0] EXP_ZERO    = 48'hC0C0C0C0C0C0;
    localparam logic [47:0] EXP_A05     = 48'hC0C0C088C092;
    localparam logic [47:0] EXP_A05_DP5 = 48'h40C0C088C092;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [95:0] src_data;
    logic [1:0]  sel;
    logic        auto_en;
    logic        freeze;
    logic [5:0]  blink_mask;
    logic [5:0]  dp_mask;
    logic [1:0]  cur_src;
    logic [1:0]  cur_src3;
    logic [47:0] hex;
    logic [47:0] hex3;

    always #5 clk = ~clk;

    seven_segment_mux_ctrl #(
        .NUM_DIGITS(6), .NUM_SRC(4), .DWELL_CYCLES(8), .BLINK_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel),
        .auto_en(auto_en), .freeze(freeze), .blink_mask(blink_mask),
        .dp_mask(dp_mask), .cur_src(cur_src), .HEX(hex)
    );

    // Three-source instance: a 2-bit sel can reach an out-of-range index here.
    seven_segment_mux_ctrl #(
        .NUM_DIGITS(6), .NUM_SRC(3), .DWELL_CYCLES(8), .BLINK_CYCLES(4)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .src_data(src_data[71:0]), .sel(sel),
        .auto_en(auto_en), .freeze(freeze), .blink_mask(blink_mask),
        .dp_mask(dp_mask), .cur_src(cur_src3), .HEX(hex3)
    );

    typedef struct {
        int          due;
        bit          dut3;
        bit          is_cur;
        logic [47:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          r0     = 0;
    exp_t        mon_e;
    logic [47:0] mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue an expectation dly clock edges from now, kept sorted by due cycle.
    task automatic expect_at(input int dly, input bit d3, input bit is_cur,
                             input logic [47:0] exp, input string name);
        exp_t e;
        int   i;
        e.due = cyc + dly; e.dut3 = d3; e.is_cur = is_cur; e.exp = exp; e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].due <= e.due) i++;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: on each falling edge, retire every expectation due at this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", mon_e.name, mon_e.due, cyc);
                end else begin
                    if (mon_e.dut3) mon_act = mon_e.is_cur ? {46'b0, cur_src3} : hex3;
                    else            mon_act = mon_e.is_cur ? {46'b0, cur_src}  : hex;
                    compare(mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int ph;
        src_data   = {24'h789012, 24'hABCDEF, 24'h123456, 24'h654321};
        sel        = 2'd0;
        auto_en    = 1'b0;
        freeze     = 1'b0;
        blink_mask = '0;
        dp_mask    = '0;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        compare("por_hex", hex, SBLANK);
        compare("por_cur", {46'b0, cur_src}, 48'd0);
        step(3);
        rst_n = 1'b1;
        r0 = cyc;
        expect_at(1, 0, 1, 48'd0,   "rel_cur");
        expect_at(1, 0, 0, EXP_ZERO, "rel_held_reset_value");
        expect_at(2, 0, 0, S654321, "rel_first_value");
        step(3);

        // Manual select
        sel = 2'd1;
        expect_at(1, 0, 1, 48'd1,   "man_cur");
        expect_at(1, 1, 1, 48'd1,   "man_cur3");
        expect_at(2, 0, 0, S654321, "man_hex_not_yet");
        expect_at(3, 0, 0, S123456, "man_hex_src1");
        step(4);
        sel = 2'd3;
        expect_at(1, 0, 1, 48'd3,   "sel3_cur");
        expect_at(3, 0, 0, S789012, "sel3_hex");
        expect_at(1, 1, 1, 48'd0,   "oob_cur3");
        expect_at(3, 1, 0, S654321, "oob_hex3");
        step(4);

        // Auto rotation
        sel = 2'd0;
        step(3);
        auto_en = 1'b1;
        expect_at(7,  0, 1, 48'd0,   "auto_cur_dwell0");
        expect_at(8,  0, 1, 48'd1,   "auto_cur_1");
        expect_at(16, 0, 1, 48'd2,   "auto_cur_2");
        expect_at(18, 0, 0, SABCDEF, "auto_hex_src2");
        expect_at(24, 0, 1, 48'd3,   "auto_cur_3");
        expect_at(31, 0, 1, 48'd3,   "auto_cur_3_end");
        expect_at(32, 0, 1, 48'd0,   "auto_cur_wrap");
        expect_at(16, 1, 1, 48'd2,   "auto_cur3_2");
        expect_at(24, 1, 1, 48'd0,   "auto_cur3_wrap");
        step(34);
        sel     = 2'd2;
        auto_en = 1'b0;
        expect_at(1, 0, 1, 48'd2, "auto_off_cur");
        expect_at(1, 1, 1, 48'd2, "auto_off_cur3");
        step(2);

        // Freeze
        sel = 2'd0;
        src_data[23:0] = 24'h000000;
        expect_at(3, 0, 0, EXP_ZERO, "frz_pre");
        step(3);
        freeze = 1'b1;
        step(1);
        src_data[23:0] = 24'hFFFFFF;
        expect_at(2, 0, 0, EXP_ZERO, "frz_hold_a");
        expect_at(4, 0, 0, EXP_ZERO, "frz_hold_b");
        step(4);
        freeze = 1'b0;
        expect_at(1, 0, 0, EXP_ZERO, "frz_rel_1");
        expect_at(2, 0, 0, SFFFFFF,  "frz_rel_2");
        step(3);

        // Blink and decimal point; phase derived from cycles since reset release
        blink_mask = 6'b000001;
        dp_mask    = 6'b000010;
        for (int k = 1; k <= 8; k++) begin
            ph = (((cyc + k) - r0 - 1) / 4) % 2;
            expect_at(k, 0, 0, (ph == 1) ? 48'h8E8E8E8E0EFF : 48'h8E8E8E8E0E8E, "blink_dp");
        end
        step(9);
        blink_mask = '0;
        dp_mask    = '0;

        // Leading-zero handling (expectations depend on build)
        src_data[23:0] = 24'h000A05;
        expect_at(2, 0, 0, EXP_A05, "lz_a05");
        step(3);
        dp_mask = 6'b100000;
        expect_at(1, 0, 0, EXP_A05_DP5, "lz_a05_dp5");
        step(2);
        dp_mask = '0;
        src_data[23:0] = 24'h000000;
        expect_at(2, 0, 0, EXP_ZERO, "lz_zero");
        step(3);

        // Mid-run asynchronous reset
        sel = 2'd2;
        step(3);
        #2;
        rst_n = 1'b0;
        sel   = 2'd0;
        src_data[23:0] = 24'h654321;
        #1;
        compare("mid_rst_hex",  hex,  SBLANK);
        compare("mid_rst_cur",  {46'b0, cur_src},  48'd0);
        compare("mid_rst_hex3", hex3, SBLANK);
        compare("mid_rst_cur3", {46'b0, cur_src3}, 48'd0);
        step(2);
        rst_n = 1'b1;
        expect_at(1, 0, 0, EXP_ZERO, "mid_rel_1");
        expect_at(2, 0, 0, S654321,  "mid_rel_2");
        step(3);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked (due %0d)", mon_e.name, mon_e.due);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
